// File: rtl/pwm_timer_pkg.sv
// Shared constants for the PWM time base: counting modes and default widths.
package pwm_timer_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_PSC_W = 8;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_UPDN = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/pwm_prescaler.sv
// Integer clock prescaler: one tick every prescale+1 clocks while clr is low.
module pwm_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;

    // >= rather than == so a prescale lowered below the running count still wraps
    always_comb begin
        psc_d = psc_q + PSC_W'(1);
        if (clr || (psc_q >= prescale)) begin
            psc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    assign tick = ~clr & (psc_q == prescale);

endmodule

// File: rtl/pwm_timer_counter.sv
// PWM time base: prescaled up/down/centre-aligned counter with shadowed period,
// one-shot operation and registered overflow/underflow pulses.
module pwm_timer_counter
    import pwm_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic [1:0]       mode,
    input  logic             one_shot,
    input  logic [CNT_W-1:0] period,
    input  logic             period_wr,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] count_val,
    output logic             dir,
    output logic             ovf_evt,
    output logic             unf_evt,
    output logic             running
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             os_done_q, os_done_d;
    logic             pend_q, pend_d;
    logic             tick;
    logic             upd_evt;
    logic [CNT_W-1:0] period_new;

    assign running = en & ~os_done_q;

    pwm_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (count_reset | ~running),
        .prescale (prescale),
        .tick     (tick)
    );

    // A write in the same cycle as an update event must win over the old shadow value
    assign period_new = (pend_q | period_wr) ? period : period_sh_q;

    always_comb begin
        count_d     = count_q;
        dir_d       = dir_q;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        os_done_d   = os_done_q;
        pend_d      = pend_q | period_wr;
        period_sh_d = period_sh_q;
        upd_evt     = 1'b0;

        if (count_reset) begin
            period_sh_d = period;
            pend_d      = 1'b0;
            os_done_d   = 1'b0;
            count_d     = (mode == MODE_DOWN) ? period : '0;
            dir_d       = (mode != MODE_DOWN);
        end else if (!en) begin
            os_done_d = 1'b0;
            if (pend_q | period_wr) begin
                period_sh_d = period;
                pend_d      = 1'b0;
            end
        end else if (tick) begin
            case (mode)
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == '0) begin
                        count_d = period_new;
                        unf_d   = 1'b1;
                        upd_evt = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                MODE_UPDN: begin
                    // Zero period: parked at 0, turning at top every tick
                    if (period_sh_q == '0) begin
                        count_d = '0;
                        ovf_d   = 1'b1;
                        upd_evt = 1'b1;
                    end else if (dir_q) begin
                        if (count_q >= period_sh_q) begin
                            dir_d   = 1'b0;
                            count_d = period_sh_q - ONE;
                            ovf_d   = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else begin
                        if (count_q == '0) begin
                            dir_d   = 1'b1;
                            count_d = ONE;
                            unf_d   = 1'b1;
                            upd_evt = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                MODE_UP, MODE_RSVD: begin
                    dir_d = 1'b1;
                    if (count_q >= period_sh_q) begin
                        count_d = '0;
                        ovf_d   = 1'b1;
                        upd_evt = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase

            if (upd_evt) begin
                period_sh_d = period_new;
                pend_d      = 1'b0;
            end
            if (one_shot && (ovf_d || unf_d)) begin
                os_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            period_sh_q <= '0;
            dir_q       <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            os_done_q   <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            period_sh_q <= period_sh_d;
            dir_q       <= dir_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            os_done_q   <= os_done_d;
            pend_q      <= pend_d;
        end
    end

    assign count_val = count_q;
    assign dir       = dir_q;
    assign ovf_evt   = ovf_q;
    assign unf_evt   = unf_q;

endmodule

// File: tb/tb_pwm_timer_counter.sv
// Directed bench for pwm_timer_counter with hand-computed expected sequences.
module tb_pwm_timer_counter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        count_reset;
    logic [1:0]  mode;
    logic        one_shot;
    logic [15:0] period;
    logic        period_wr;
    logic [7:0]  prescale;
    logic [15:0] count_val;
    logic        dir;
    logic        ovf_evt;
    logic        unf_evt;
    logic        running;

    int n_vec = 0;
    int n_err = 0;

    pwm_timer_counter #(.CNT_W(16), .PSC_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_reset (count_reset),
        .mode        (mode),
        .one_shot    (one_shot),
        .period      (period),
        .period_wr   (period_wr),
        .prescale    (prescale),
        .count_val   (count_val),
        .dir         (dir),
        .ovf_evt     (ovf_evt),
        .unf_evt     (unf_evt),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int c, input int d, input int o, input int u);
        check({tag, ".count"}, 32'(count_val), c[31:0]);
        check({tag, ".dir"}, 32'(dir), d[31:0]);
        check({tag, ".ovf"}, 32'(ovf_evt), o[31:0]);
        check({tag, ".unf"}, 32'(unf_evt), u[31:0]);
    endtask

    int up_exp[5]   = '{1, 2, 3, 4, 0};
    int dn_exp[4]   = '{2, 1, 0, 3};
    int ud_cnt[7]   = '{1, 2, 3, 2, 1, 0, 1};
    int ud_dir[7]   = '{1, 1, 1, 0, 0, 0, 1};
    int ud_ovf[7]   = '{0, 0, 0, 1, 0, 0, 0};
    int ud_unf[7]   = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst_n = 1'b0; en = 1'b0; count_reset = 1'b0; mode = 2'd0; one_shot = 1'b0;
        period = 16'd0; period_wr = 1'b0; prescale = 8'd0;
        step(2);
        check_state("reset", 0, 1, 0, 0);
        check("reset.running", 32'(running), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Up mode, period 4, prescale 0
        mode = 2'd0; period = 16'd4; prescale = 8'd0; en = 1'b1; count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        check_state("up.clr", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_state($sformatf("up[%0d]", i), up_exp[i], 1, (i == 4) ? 1 : 0, 0);
        end
        step(1);
        check_state("up.after", 1, 1, 0, 0);
        en = 1'b0;
        step(3);
        check("freeze.count", 32'(count_val), 32'd1);
        check("freeze.running", 32'(running), 32'd0);
        en = 1'b1;

        // Down mode, period 3, prescale 2
        mode = 2'd1; period = 16'd3; prescale = 8'd2; count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        check_state("dn.clr", 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = (i == 0) ? 3 : dn_exp[i-1];
            step(1);
            check_state($sformatf("dn[%0d].h1", i), prev, 0, 0, 0);
            step(1);
            check($sformatf("dn[%0d].h2", i), 32'(count_val), prev[31:0]);
            step(1);
            check_state($sformatf("dn[%0d]", i), dn_exp[i], 0, 0, (i == 3) ? 1 : 0);
        end

        // Centre-aligned, period 3
        mode = 2'd2; period = 16'd3; prescale = 8'd0; count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        check_state("ud.clr", 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            check_state($sformatf("ud[%0d]", i), ud_cnt[i], ud_dir[i], ud_ovf[i], ud_unf[i]);
        end

        // Shadowed period: 10 -> 5 written at count 2
        mode = 2'd0; period = 16'd10; prescale = 8'd0; count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        step(2);
        check("sh.at2", 32'(count_val), 32'd2);
        period = 16'd5; period_wr = 1'b1;
        step(1);
        period_wr = 1'b0;
        check("sh.at3", 32'(count_val), 32'd3);
        step(7);
        check_state("sh.top10", 10, 1, 0, 0);
        step(1);
        check_state("sh.wrap10", 0, 1, 1, 0);
        step(5);
        check_state("sh.top5", 5, 1, 0, 0);
        step(1);
        check_state("sh.wrap5", 0, 1, 1, 0);

        // One-shot, up mode, period 2
        mode = 2'd0; period = 16'd2; one_shot = 1'b1; count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        step(2);
        check("os.at2", 32'(count_val), 32'd2);
        step(1);
        check_state("os.wrap", 0, 1, 1, 0);
        check("os.running", 32'(running), 32'd0);
        step(3);
        check_state("os.hold", 0, 1, 0, 0);
        check("os.hold.running", 32'(running), 32'd0);
        count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        check("os.rearm.running", 32'(running), 32'd1);
        step(1);
        check("os.rearm.count", 32'(count_val), 32'd1);
        one_shot = 1'b0;

        // Async reset mid-count with prescaler part-way through
        mode = 2'd0; period = 16'd20; prescale = 8'd3; count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        step(28);
        check("rst.at7", 32'(count_val), 32'd7);
        step(2);
        rst_n = 1'b0;
        #1;
        check_state("rst.async", 0, 1, 0, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check_state("rst.psc3", 0, 1, 0, 0);
        step(1);
        check_state("rst.psc4", 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
